// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor computing diff = a - b one
//                bit per clock, LSB first, behind a start/done handshake.
//                The final borrow flags a < b.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // One spare counter bit so the compare against WIDTH-1 can never see a wrap.
    localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_bw;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    logic               w_d;
    logic               w_bw_next;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    // Full-subtractor cell on the current LSBs plus the running borrow.
    always_comb begin
        w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_bw;
        w_bw_next  = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_bw);
        w_res_next = {w_d, r_res_sr[WIDTH-1:1]};
        w_last     = (r_cnt == c_CNT_LAST);
    end

    // Control FSM and serial datapath; busy/done are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_res_sr <= '0;
                        r_bw     <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= c_ST_SHIFT;
                        r_busy   <= 1'b1;
                    end
                end
                c_ST_SHIFT: begin
                    r_res_sr <= w_res_next;
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_bw     <= w_bw_next;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                    if (w_last) begin
                        // Publish the completed result alongside the done pulse.
                        r_diff   <= w_res_next;
                        r_borrow <= w_bw_next;
                        r_state  <= c_ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule
`default_nettype wire
